// File: rtl/mux_nto1_rr.sv
// N-to-1 valid/ready stream mux with a registered output stage, manual or round-robin selection.
// Define MUX_PKT_LOCK_EN to add in_last/out_last and hold round-robin grants for whole packets.
module mux_nto1_rr #(
   parameter  int unsigned N    = 4,
   parameter  int unsigned W    = 8,
   localparam int unsigned SELW = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode,
   input  logic [SELW-1:0]   sel,
   input  logic [N-1:0]      in_valid,
   input  logic [N*W-1:0]    in_data,
`ifdef MUX_PKT_LOCK_EN
   input  logic [N-1:0]      in_last,
   output logic              out_last,
`endif
   output logic [N-1:0]      in_ready,
   output logic              out_valid,
   output logic [W-1:0]      out_data,
   output logic [SELW-1:0]   out_chan,
   input  logic              out_ready
);

   logic [SELW-1:0] ptr;
   logic            load_c;
   logic            rr_hit_c;
   logic [SELW-1:0] rr_grant_c;
   logic            grant_valid_c;
   logic [SELW-1:0] grant_c;
   logic [W-1:0]    grant_data_c;
   logic [SELW-1:0] ptr_next_c;
   int unsigned     idx;
`ifdef MUX_PKT_LOCK_EN
   logic            lock;
   logic [SELW-1:0] lock_chan;
   logic            grant_last_c;
`endif

   assign load_c = !out_valid || out_ready;

   // Round-robin scan starting at ptr, wrapping below N
   always_comb begin
      rr_hit_c   = 1'b0;
      rr_grant_c = '0;
      idx        = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!rr_hit_c && in_valid[SELW'(idx)]) begin
            rr_hit_c   = 1'b1;
            rr_grant_c = SELW'(idx);
         end
      end
   end

   // Grant decision for the current cycle
   always_comb begin
      grant_valid_c = 1'b0;
      grant_c       = '0;
      if (!mode) begin
         if (32'(sel) < N) begin
            grant_valid_c = in_valid[sel];
            grant_c       = sel;
         end
      end else begin
         grant_valid_c = rr_hit_c;
         grant_c       = rr_grant_c;
`ifdef MUX_PKT_LOCK_EN
         if (lock) begin
            grant_valid_c = in_valid[lock_chan];
            grant_c       = lock_chan;
         end
`endif
      end
   end

   always_comb begin
      grant_data_c = '0;
`ifdef MUX_PKT_LOCK_EN
      grant_last_c = 1'b0;
`endif
      for (int unsigned i = 0; i < N; i++) begin
         if (grant_c == SELW'(i)) begin
            grant_data_c = in_data[i*W +: W];
`ifdef MUX_PKT_LOCK_EN
            grant_last_c = in_last[i];
`endif
         end
      end
   end

   assign ptr_next_c = (32'(grant_c) == N - 1) ? '0 : SELW'(32'(grant_c) + 1);

   // Nothing is accepted while reset is held
   always_comb begin
      in_ready = '0;
      if (rst_n && load_c && grant_valid_c) in_ready[grant_c] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= '0;
`ifdef MUX_PKT_LOCK_EN
         out_last  <= 1'b0;
         lock      <= 1'b0;
         lock_chan <= '0;
`endif
      end else begin
         if (load_c) begin
            if (grant_valid_c) begin
               out_valid <= 1'b1;
               out_data  <= grant_data_c;
               out_chan  <= grant_c;
`ifdef MUX_PKT_LOCK_EN
               out_last  <= grant_last_c;
               if (mode && grant_last_c) ptr <= ptr_next_c;
`else
               if (mode) ptr <= ptr_next_c;
`endif
            end else begin
               out_valid <= 1'b0;
            end
         end
`ifdef MUX_PKT_LOCK_EN
         // Lock holds only in round-robin mode; leaving it drops the lock
         if (!mode) begin
            lock <= 1'b0;
         end else if (load_c && grant_valid_c) begin
            lock      <= !grant_last_c;
            lock_chan <= grant_c;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Scoreboard bench for mux_nto1_rr: stimulus pushes expected words, a monitor pops them on output handshakes.
module tb_mux_nto1_rr;

   localparam int unsigned N    = 4;
   localparam int unsigned W    = 8;
   localparam int unsigned SELW = 2;

   logic              clk;
   logic              rst_n;
   logic              mode;
   logic [SELW-1:0]   sel;
   logic [N-1:0]      in_valid;
   logic [N*W-1:0]    in_data;
   logic [N-1:0]      in_ready;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic [SELW-1:0]   out_chan;
   logic              out_ready;
`ifdef MUX_PKT_LOCK_EN
   logic [N-1:0]      in_last;
   logic              out_last;
`endif

   logic [SELW+W-1:0] exp_q[$];
   int                errors;
   int                checks;

   mux_nto1_rr #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
`ifdef MUX_PKT_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [N*W-1:0] mk(input int seq);
      logic [N*W-1:0] d;
      for (int i = 0; i < N; i++) d[i*W +: W] = W'(seq * 16 + i);
      return d;
   endfunction

   // One cycle of stimulus, starting just after a rising edge
   task automatic step(input logic [N*W-1:0] din, input logic m, input logic [SELW-1:0] s,
                       input logic [N-1:0] v, input logic ordy, input logic [N-1:0] exp_rdy,
                       input string name);
      in_data   = din;
      mode      = m;
      sel       = s;
      in_valid  = v;
      out_ready = ordy;
      #2;
      check(name, 32'(in_ready), 32'(exp_rdy));
      for (int i = 0; i < N; i++)
         if (exp_rdy[i]) exp_q.push_back({SELW'(i), din[i*W +: W]});
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      logic [SELW+W-1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL out_word: unexpected word chan=%0d data=%0h, expected none", out_chan, out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_word", 32'({out_chan, out_data}), 32'(e));
            end
         end
      end
   endtask

   initial begin
      logic [N*W-1:0] d;
      errors    = 0;
      checks    = 0;
      rst_n     = 1'b0;
      mode      = 1'b1;
      sel       = '0;
      in_valid  = '1;
      in_data   = mk(0);
      out_ready = 1'b1;
`ifdef MUX_PKT_LOCK_EN
      in_last   = '1;
`endif
      fork
         monitor();
      join_none

      // Reset with all channels requesting
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(out_valid), 0);
      check("reset_out_data", 32'(out_data), 0);
      check("reset_out_chan", 32'(out_chan), 0);
      check("reset_in_ready", 32'(in_ready), 0);
      rst_n = 1'b1;

      // Manual selection
      d = mk(1);
      d[2*W +: W] = 8'hA5;
      step(d, 1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, "manual_sel2");
      step(mk(2), 1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, "manual_sel_invalid");

      // Round-robin over all channels, then over channels 1 and 3
      for (int k = 0; k < 5; k++)
         step(mk(3 + k), 1'b1, 2'd0, 4'hF, 1'b1, 4'(1 << (k % 4)), "rr_all");
      for (int k = 0; k < 4; k++)
         step(mk(8 + k), 1'b1, 2'd0, 4'b1010, 1'b1, (k % 2 == 0) ? 4'b0010 : 4'b1000, "rr_1010");

      // Backpressure holds channel 3 word of mk(11) = 8'hB3
      for (int k = 0; k < 3; k++) begin
         step(mk(12 + k), 1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, "bp_in_ready");
         check("bp_out_valid", 32'(out_valid), 1);
         check("bp_out_data", 32'(out_data), 32'h0000_00B3);
         check("bp_out_chan", 32'(out_chan), 3);
      end
      step(mk(15), 1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, "bp_release");
      step(mk(16), 1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, "idle");
      check("idle_out_valid", 32'(out_valid), 0);

      // Pointer wrap from 3 to channel 0
      step(mk(17), 1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, "rr_to_ptr3");
      step(mk(18), 1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, "wrap_grant0");
      step(mk(19), 1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, "ptr_after_wrap");
      step(mk(20), 1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, "rr_to_ptr3_again");

      // Reset while a word is held: the word is dropped and ptr returns to 0
      rst_n = 1'b0;
      exp_q.delete();
      step(mk(21), 1'b1, 2'd0, 4'hF, 1'b1, 4'b0000, "in_ready_in_reset");
      check("reset_mid_out_valid", 32'(out_valid), 0);
      check("reset_mid_out_chan", 32'(out_chan), 0);
      rst_n = 1'b1;
      step(mk(22), 1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, "ptr_after_reset");

`ifdef MUX_PKT_LOCK_EN
      // Three-word packet on channel 1 while channel 2 waits
      in_last = 4'b0000;
      step(mk(23), 1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, "pkt_word1");
      step(mk(24), 1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, "pkt_word2");
      in_last = 4'b0010;
      step(mk(25), 1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, "pkt_word3");
      in_last = '1;
      step(mk(26), 1'b1, 2'd0, 4'b0110, 1'b1, 4'b0100, "pkt_next_chan");
`endif

      step(mk(27), 1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, "drain");
      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", 32'(exp_q.size()), 0);
      check("final_out_valid", 32'(out_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
